// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types and constants for the memory bus arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } arb_state_e;

  localparam int PORT_CPU   = 0;
  localparam int PORT_LDR   = 1;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 8;

endpackage

`default_nettype wire

// File: rtl/mem_arb_sel.sv
// ============================================================================
// mem_arb_sel : combinational 2-way grant selector (round-robin or fixed)
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arb_sel
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_winner,
  output logic       o_valid
);

  always_comb begin
    o_valid  = |i_req;
    o_winner = 1'(PORT_CPU);
    case (i_req)
      2'b01:   o_winner = 1'(PORT_CPU);
      2'b10:   o_winner = 1'(PORT_LDR);
      // On a tie the CPU wins outright in fixed mode, else the port not served last
      2'b11:   o_winner = FIXED_PRIO ? 1'(PORT_CPU) : ~i_last_grant;
      default: o_winner = 1'(PORT_CPU);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : two-port arbiter and strobe sequencer for the memory bus
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ACCESS_CYCLES = 2,
  parameter bit FIXED_PRIO    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [3:0] c_CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  arb_state_e r_state;
  logic [3:0] r_cnt;
  logic       r_last_grant;
  logic       w_win;
  logic       w_valid;

  mem_arb_sel #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_sel (
    .i_req        (req),
    .i_last_grant (r_last_grant),
    .o_winner     (w_win),
    .o_valid      (w_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      owner        <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ack          <= 2'b00;
      rdata0       <= '0;
      rdata1       <= '0;
      busy         <= 1'b0;
    end else begin
      ack <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            owner        <= w_win;
            r_last_grant <= w_win;
            mem_addr     <= w_win ? addr1  : addr0;
            mem_wdata    <= w_win ? wdata1 : wdata0;
            mem_rd       <= ~we[w_win];
            mem_wr       <= we[w_win];
            r_cnt        <= c_CNT_LOAD;
            busy         <= 1'b1;
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Final strobe edge: read data is sampled here, then the bus is released
            if (mem_rd) begin
              if (owner == 1'(PORT_LDR)) rdata1 <= mem_rdata;
              else                       rdata0 <= mem_rdata;
            end
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            ack[owner] <= 1'b1;
            r_state    <= RECOVER;
          end
        end
        RECOVER: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          mem_rd  <= 1'b0;
          mem_wr  <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : randomized scoreboard bench over four arbiter configs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int NCFG    = 4;
  localparam int RUN_CYC = 2400;

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  logic clk    = 1'b0;

  always #5 clk = ~clk;

  // Memory contents are a fixed function of address so read data is predictable
  function automatic logic [7:0] mem_f(input logic [12:0] a);
    return a[7:0] ^ {a[12:8], 3'b101} ^ 8'h3C;
  endfunction

  task automatic check(input int cfg, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h at %0t", cfg, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int AC = (g == 2) ? 1 : ((g == 3) ? 15 : 2);
    localparam bit FP = (g == 1);

    logic        rst_n;
    logic [1:0]  req, we, ack;
    logic [12:0] addr0, addr1, mem_addr;
    logic [7:0]  wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, busy, owner;
    txn_t        q0[$];
    txn_t        q1[$];
    bit          pend0, pend1;

    assign mem_rdata = mem_f(mem_addr);

    mem_bus_arbiter #(
      .ADDR_W        (13),
      .DATA_W        (8),
      .ACCESS_CYCLES (AC),
      .FIXED_PRIO    (FP)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .we        (we),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .ack       (ack),
      .rdata0    (rdata0),
      .rdata1    (rdata1),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .owner     (owner)
    );

    task automatic issue(input bit p, input logic w, input logic [12:0] a, input logic [7:0] d);
      txn_t t;
      t.we = w; t.addr = a; t.wdata = d;
      if (p) begin
        req[1] = 1'b1; we[1] = w; addr1 = a; wdata1 = d; pend1 = 1'b1; q1.push_back(t);
      end else begin
        req[0] = 1'b1; we[0] = w; addr0 = a; wdata0 = d; pend0 = 1'b1; q0.push_back(t);
      end
    endtask

    task automatic retire();
      if (pend0 && ack[0]) begin pend0 = 1'b0; req[0] = 1'b0; end
      if (pend1 && ack[1]) begin pend1 = 1'b0; req[1] = 1'b0; end
    endtask

    task automatic drain(input string name);
      int k;
      k = 0;
      while ((pend0 || pend1) && k < 500) begin
        @(negedge clk);
        retire();
        k++;
      end
      check(g, name, {pend1, pend0}, 2'b00);
    endtask

    task automatic wait_strobe(input string name);
      int k;
      k = 0;
      while (!(mem_rd || mem_wr) && k < 60) begin
        @(negedge clk);
        k++;
      end
      check(g, name, mem_rd | mem_wr, 1'b1);
    endtask

    initial begin : stim
      int pct;
      rst_n = 1'b0; req = 2'b00; we = 2'b00;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      pend0 = 1'b0; pend1 = 1'b0;
      repeat (3) @(negedge clk);
      check(g, "reset_state", {mem_rd, mem_wr, ack, busy, owner, rdata0, rdata1}, '0);
      rst_n = 1'b1;
      @(negedge clk);
      issue(1'b0, 1'b0, 13'h00A5, 8'h00);
      issue(1'b1, 1'b1, 13'h1FFF, 8'h7F);
      for (int c = 0; c < RUN_CYC; c++) begin
        @(negedge clk);
        retire();
        // First half saturates both ports to exercise tie-breaking
        pct = (c < RUN_CYC / 2) ? 100 : 25;
        if (!pend0 && $urandom_range(99) < pct)
          issue(1'b0, 1'($urandom), 13'($urandom), 8'($urandom));
        if (!pend1 && $urandom_range(99) < pct)
          issue(1'b1, 1'($urandom), 13'($urandom), 8'($urandom));
      end
      drain("drain_before_reset");

      issue(1'b0, 1'b0, 13'($urandom), 8'h00);
      issue(1'b1, 1'b0, 13'($urandom), 8'h00);
      wait_strobe("strobe_before_reset");
      if (AC >= 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check(g, "reset_async", {mem_rd, mem_wr, ack, busy, owner, rdata0, rdata1}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_strobe("strobe_after_reset");
      check(g, "tie_after_reset", {owner, mem_addr}, {1'b0, addr0});
      drain("drain_final");
      n_done++;
    end

    initial begin : mon
      bit          last_g, act, stable, cur_p, cur_we, exp_w, strobe;
      int          slen, gap;
      logic [12:0] cur_a;
      logic [7:0]  cur_wd, exp_rd0, exp_rd1;
      txn_t        t;
      last_g = 1'b1; act = 1'b0; stable = 1'b1; cur_p = 1'b0; cur_we = 1'b0;
      slen = 0; gap = 2; cur_a = '0; cur_wd = '0; exp_rd0 = '0; exp_rd1 = '0;
      forever begin
        @(posedge clk);
        #1;
        if (rst_n !== 1'b1) begin
          last_g = 1'b1; act = 1'b0; gap = 2; exp_rd0 = '0; exp_rd1 = '0;
          continue;
        end
        strobe = mem_rd | mem_wr;
        check(g, "excl_busy", {mem_rd & mem_wr, busy}, {1'b0, strobe | (|ack)});
        if (strobe && !act) begin
          check(g, "recover_gap", gap >= 2, 1'b1);
          check(g, "grant_has_req", |req, 1'b1);
          if (req == 2'b11) exp_w = FP ? 1'b0 : ~last_g;
          else              exp_w = req[1] & ~req[0];
          check(g, "grant_owner", owner, exp_w);
          last_g = exp_w; cur_p = exp_w; act = 1'b1; slen = 1; stable = 1'b1;
          cur_a = mem_addr; cur_we = mem_wr; cur_wd = mem_wdata;
          check(g, "grant_queue", exp_w ? q1.size() : q0.size(), 1);
          if ((exp_w ? q1.size() : q0.size()) > 0) begin
            t = exp_w ? q1[0] : q0[0];
            check(g, "grant_cmd", {mem_wr, mem_rd, mem_addr}, {t.we, ~t.we, t.addr});
            if (t.we) check(g, "grant_wdata", mem_wdata, t.wdata);
          end
        end else if (strobe) begin
          slen++;
          if (mem_addr !== cur_a || mem_wr !== cur_we || mem_wdata !== cur_wd || owner !== cur_p)
            stable = 1'b0;
        end else if (act) begin
          check(g, "ack", ack, cur_p ? 2'b10 : 2'b01);
          check(g, "strobe_len", slen, AC);
          check(g, "hold_stable", stable, 1'b1);
          if (!cur_we) begin
            if (cur_p) exp_rd1 = mem_f(cur_a);
            else       exp_rd0 = mem_f(cur_a);
          end
          check(g, "rdata", {rdata1, rdata0}, {exp_rd1, exp_rd0});
          if (cur_p && q1.size() > 0) void'(q1.pop_front());
          if (!cur_p && q0.size() > 0) void'(q0.pop_front());
          act = 1'b0;
          gap = 1;
        end else begin
          check(g, "no_stray_ack", ack, 2'b00);
          gap++;
        end
      end
    end
  end

  initial begin : summary
    int t;
    for (t = 0; t < 60000; t++) begin
      @(posedge clk);
      if (n_done == NCFG) break;
    end
    if (n_done != NCFG) begin
      n_vec++;
      n_err++;
      $display("FAIL global_timeout: %0d of %0d configs finished", n_done, NCFG);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
